// File: rtl/ddi_timing_controller.sv
// Dwell timer and phase arbiter for one DDI signal FSM; optional starvation guard via DDI_STARVE_GUARD_EN.
// timing_done/phase registered (1-cycle latency); no backpressure, requests latch until their phase commits.
`timescale 1ns/1ps
module ddi_timing_controller #(
  parameter int unsigned GREEN_CYCLES      = 20,
  parameter int unsigned PRIO_GREEN_CYCLES = 10,
  parameter int unsigned YELLOW_CYCLES     = 4,
  parameter int unsigned ALL_RED_CYCLES    = 2,
  parameter int unsigned CNT_W             = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] current_state,
  input  logic       maintenance,
  input  logic       east_req,
  input  logic       west_req,
  output logic       timing_done,
  output logic [1:0] phase,
  output logic       east_pending,
  output logic       west_pending
);

  localparam logic [3:0] ST_ALL_RED      = 4'd0;
  localparam logic [3:0] ST_P1_GREEN     = 4'd1;
  localparam logic [3:0] ST_P1_YELLOW    = 4'd2;
  localparam logic [3:0] ST_P2_GREEN     = 4'd3;
  localparam logic [3:0] ST_P2_YELLOW    = 4'd4;
  localparam logic [3:0] ST_EB_GREEN     = 4'd5;
  localparam logic [3:0] ST_EB_YELLOW    = 4'd6;
  localparam logic [3:0] ST_WB_GREEN     = 4'd7;
  localparam logic [3:0] ST_WB_YELLOW    = 4'd8;
  localparam logic [3:0] ST_MAINTENANCE  = 4'd9;

  typedef enum logic [1:0] {
    PHASE_1       = 2'd0,
    PHASE_2       = 2'd1,
    EAST_PRIORITY = 2'd2,
    WEST_PRIORITY = 2'd3
  } phase_e;

  logic [3:0]       prev_state_q, prev_state_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur;
  logic             timing_done_q, timing_done_d;
  phase_e           phase_q, phase_d;
  phase_e           next_normal_q, next_normal_d;
  logic             east_pending_q, east_pending_d;
  logic             west_pending_q, west_pending_d;
  logic             hold;
  logic             state_chg;
  logic             commit;
  logic             force_normal;

`ifdef DDI_STARVE_GUARD_EN
  logic guard_q, guard_d;
  assign force_normal = guard_q;
`else
  assign force_normal = 1'b0;
`endif

  always_comb begin : dur_sel
    dur = CNT_W'(ALL_RED_CYCLES);
    case (current_state)
      ST_P1_GREEN, ST_P2_GREEN:   dur = CNT_W'(GREEN_CYCLES);
      ST_EB_GREEN, ST_WB_GREEN:   dur = CNT_W'(PRIO_GREEN_CYCLES);
      ST_P1_YELLOW, ST_P2_YELLOW,
      ST_EB_YELLOW, ST_WB_YELLOW: dur = CNT_W'(YELLOW_CYCLES);
      default:                    dur = CNT_W'(ALL_RED_CYCLES);
    endcase
  end

  // cnt_d is the 1-based cycle index of the current cycle within its state;
  // the strobe is registered, so it is raised one cycle ahead at DUR-1.
  always_comb begin : dwell
    hold         = maintenance || (current_state == ST_MAINTENANCE);
    state_chg    = first_q || (current_state != prev_state_q);
    prev_state_d = current_state;
    first_d      = 1'b0;
    if (hold) begin
      cnt_d = '0;
    end else if (state_chg) begin
      cnt_d = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    timing_done_d = !hold && (cnt_d == dur - CNT_W'(1));
    commit        = !hold && (current_state == ST_ALL_RED) && (cnt_d == CNT_W'(1));
  end

  always_comb begin : commit_sel
    phase_d        = phase_q;
    next_normal_d  = next_normal_q;
    east_pending_d = east_pending_q | east_req;
    west_pending_d = west_pending_q | west_req;
`ifdef DDI_STARVE_GUARD_EN
    guard_d        = guard_q;
`endif
    if (commit) begin
      // clearing a flag on its commit overrides a same-cycle request
      if (east_pending_q && !force_normal) begin
        phase_d        = EAST_PRIORITY;
        east_pending_d = 1'b0;
      end else if (west_pending_q && !force_normal) begin
        phase_d        = WEST_PRIORITY;
        west_pending_d = 1'b0;
      end else begin
        phase_d       = next_normal_q;
        next_normal_d = (next_normal_q == PHASE_1) ? PHASE_2 : PHASE_1;
      end
`ifdef DDI_STARVE_GUARD_EN
      guard_d = (phase_d == EAST_PRIORITY) || (phase_d == WEST_PRIORITY);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state_q   <= ST_ALL_RED;
      first_q        <= 1'b1;
      cnt_q          <= '0;
      timing_done_q  <= 1'b0;
      phase_q        <= PHASE_1;
      next_normal_q  <= PHASE_1;
      east_pending_q <= 1'b0;
      west_pending_q <= 1'b0;
    end else begin
      prev_state_q   <= prev_state_d;
      first_q        <= first_d;
      cnt_q          <= cnt_d;
      timing_done_q  <= timing_done_d;
      phase_q        <= phase_d;
      next_normal_q  <= next_normal_d;
      east_pending_q <= east_pending_d;
      west_pending_q <= west_pending_d;
    end
  end

`ifdef DDI_STARVE_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      guard_q <= 1'b0;
    end else begin
      guard_q <= guard_d;
    end
  end
`endif

  assign timing_done  = timing_done_q;
  assign phase        = phase_q;
  assign east_pending = east_pending_q;
  assign west_pending = west_pending_q;

endmodule

// File: tb/tb_ddi_timing_controller.sv
// Closed-loop bench: a small signal-FSM model drives current_state; expected state visits
// (state, dwell, strobe count, committed phase) are queued up front and popped as each visit ends.
`timescale 1ns/1ps
module tb_ddi_timing_controller;

  localparam int GREEN = 20;
  localparam int PRIO  = 10;
  localparam int YEL   = 4;
  localparam int AR    = 2;

  localparam logic [3:0] S_AR = 4'd0, S_P1G = 4'd1, S_P1Y = 4'd2, S_P2G = 4'd3, S_P2Y = 4'd4;
  localparam logic [3:0] S_EBG = 4'd5, S_EBY = 4'd6, S_WBG = 4'd7, S_WBY = 4'd8, S_MNT = 4'd9;
  localparam logic [1:0] PH_1 = 2'd0, PH_2 = 2'd1, PH_E = 2'd2, PH_W = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cur_state = S_AR;
  logic       maint = 1'b0;
  logic       east_req = 1'b0;
  logic       west_req = 1'b0;
  logic       timing_done;
  logic [1:0] phase;
  logic       east_pending;
  logic       west_pending;

  ddi_timing_controller #(
    .GREEN_CYCLES(GREEN), .PRIO_GREEN_CYCLES(PRIO), .YELLOW_CYCLES(YEL),
    .ALL_RED_CYCLES(AR), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .current_state(cur_state), .maintenance(maint),
    .east_req(east_req), .west_req(west_req), .timing_done(timing_done),
    .phase(phase), .east_pending(east_pending), .west_pending(west_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    int         dwell;
    int         tds;
    logic [1:0] ph;
  } vis_t;

  vis_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic       td_s = 1'b0;
  logic [1:0] ph_s = 2'd0;
  logic       tb_hold = 1'b0;
  logic [3:0] force_state = S_AR;
  logic       sb_en = 1'b0;
  logic       trk_restart = 1'b0;
  logic [3:0] vis_st = S_AR;
  int         vis_len = 0;
  int         vis_td = 0;
  logic [1:0] vis_ph = 2'd0;
  logic [1:0] exp_nn = PH_1;

  task automatic check_val(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nxt_state(input logic [3:0] s, input logic [1:0] ph);
    case (s)
      S_AR:    case (ph)
                 PH_1:    nxt_state = S_P1G;
                 PH_2:    nxt_state = S_P2G;
                 PH_E:    nxt_state = S_EBG;
                 default: nxt_state = S_WBG;
               endcase
      S_P1G:   nxt_state = S_P1Y;
      S_P2G:   nxt_state = S_P2Y;
      S_EBG:   nxt_state = S_EBY;
      S_WBG:   nxt_state = S_WBY;
      default: nxt_state = S_AR;
    endcase
  endfunction

  function automatic void push_visit(input logic [3:0] st, input int dw, input int tds, input logic [1:0] ph);
    vis_t v;
    v.st = st; v.dwell = dw; v.tds = tds; v.ph = ph;
    sb_q.push_back(v);
  endfunction

  function automatic void push_normal();
    logic [1:0] ph;
    ph = exp_nn;
    exp_nn = (exp_nn == PH_1) ? PH_2 : PH_1;
    push_visit(S_AR, AR, 1, ph);
    push_visit((ph == PH_1) ? S_P1G : S_P2G, GREEN, 1, 2'd0);
    push_visit((ph == PH_1) ? S_P1Y : S_P2Y, YEL, 1, 2'd0);
  endfunction

  function automatic void push_prio(input logic east);
    push_visit(S_AR, AR, 1, east ? PH_E : PH_W);
    push_visit(east ? S_EBG : S_WBG, PRIO, 1, 2'd0);
    push_visit(east ? S_EBY : S_WBY, YEL, 1, 2'd0);
  endfunction

  task automatic end_visit();
    vis_t e;
    if (!sb_en) return;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_val("visit_state", int'(vis_st), int'(e.st));
      check_val($sformatf("dwell_s%0d", e.st), vis_len, e.dwell);
      check_val($sformatf("strobes_s%0d", e.st), vis_td, e.tds);
      if (e.st == S_AR) check_val("ar_phase", int'(vis_ph), int'(e.ph));
    end
  endtask

  // FSM model: advances on the edge after a sampled strobe, 1 ns past the edge
  task automatic adv();
    @(posedge clk);
    #1;
    if (rst)                    cur_state = S_AR;
    else if (tb_hold)           cur_state = force_state;
    else if (maint)             cur_state = S_MNT;
    else if (cur_state == S_MNT) cur_state = S_AR;
    else if (td_s)              cur_state = nxt_state(cur_state, ph_s);
  endtask

  task automatic smp();
    @(negedge clk);
    td_s = timing_done;
    ph_s = phase;
    if (trk_restart || cur_state != vis_st) begin
      if (!trk_restart) end_visit();
      trk_restart = 1'b0;
      vis_st  = cur_state;
      vis_len = 1;
      vis_td  = td_s ? 1 : 0;
      vis_ph  = 2'd0;
    end else begin
      vis_len++;
      if (td_s) vis_td++;
    end
    if (vis_st == S_AR && vis_len == 2) vis_ph = ph_s;
  endtask

  task automatic cyc();
    adv();
    smp();
  endtask

  task automatic run_until(input logic [3:0] st, input int len, input string tag);
    int n = 0;
    while (!(cur_state == st && vis_len == len) && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) check_val({"timeout_", tag}, n, 0);
  endtask

  task automatic drain_to(input int left, input string tag);
    int n = 0;
    while (sb_q.size() > left && n < 600) begin
      cyc();
      n++;
    end
    if (n >= 600) check_val({"timeout_", tag}, sb_q.size(), left);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset dominates requests
    east_req = 1'b1;
    west_req = 1'b1;
    repeat (3) cyc();
    check_val("rst_td", int'(timing_done), 0);
    check_val("rst_phase", int'(phase), int'(PH_1));
    check_val("rst_east_pend", int'(east_pending), 0);
    check_val("rst_west_pend", int'(west_pending), 0);
    east_req = 1'b0;
    west_req = 1'b0;

    exp_nn = PH_1;
    push_normal();
    push_normal();
    push_normal();
    push_prio(1'b1);
    push_normal();
    adv();
    rst = 1'b0;
    trk_restart = 1'b1;
    sb_en = 1'b1;
    smp();

    // single-cycle east pulse in PHASE_1_GREEN
    drain_to(9, "scen2_start");
    run_until(S_P1G, 5, "east_pulse");
    east_req = 1'b1;
    cyc();
    east_req = 1'b0;
    check_val("east_latched", int'(east_pending), 1);
    run_until(S_EBG, 1, "east_served");
    check_val("east_cleared", int'(east_pending), 0);

    push_prio(1'b1);
`ifdef DDI_STARVE_GUARD_EN
    push_normal();
    push_prio(1'b0);
`else
    push_prio(1'b0);
    push_normal();
`endif
    run_until(S_P2Y, 2, "both_pulse");
    east_req = 1'b1;
    west_req = 1'b1;
    cyc();
    east_req = 1'b0;
    west_req = 1'b0;
    check_val("both_east_pend", int'(east_pending), 1);
    check_val("both_west_pend", int'(west_pending), 1);
    drain_to(0, "scen3_drain");

    // FSM stalled in PHASE_2_GREEN: one strobe at cycle 20 only
    push_visit(S_AR, AR, 1, exp_nn);
    exp_nn = (exp_nn == PH_1) ? PH_2 : PH_1;
    push_visit(S_P2G, 30, 1, 2'd0);
    run_until(S_AR, 2, "hold_entry");
    tb_hold = 1'b1;
    force_state = S_P2G;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      check_val($sformatf("hold_td_c%0d", k), int'(td_s), (k == GREEN) ? 1 : 0);
    end
    force_state = S_AR;
    cyc();
    tb_hold = 1'b0;

    // maintenance mid-green with an east request pending
    push_visit(S_AR, AR, 1, exp_nn);
    exp_nn = (exp_nn == PH_1) ? PH_2 : PH_1;
    push_visit(S_P1G, 6, 0, 2'd0);
    push_visit(S_MNT, 15, 0, 2'd0);
    push_prio(1'b1);
    push_normal();
    run_until(S_P1G, 3, "mnt_req");
    east_req = 1'b1;
    cyc();
    east_req = 1'b0;
    run_until(S_P1G, 6, "mnt_entry");
    maint = 1'b1;
    repeat (15) cyc();
    maint = 1'b0;
    check_val("mnt_keeps_east", int'(east_pending), 1);
    drain_to(0, "mnt_drain");

    // reset in cycle 7 of PHASE_1_GREEN with west pending
    sb_en = 1'b0;
    run_until(S_P1G, 2, "rst_req");
    west_req = 1'b1;
    cyc();
    west_req = 1'b0;
    run_until(S_P1G, 6, "rst_entry");
    check_val("pre_rst_west_pend", int'(west_pending), 1);
    adv();
    rst = 1'b1;
    smp();
    adv();
    smp();
    check_val("mid_rst_td", int'(timing_done), 0);
    check_val("mid_rst_phase", int'(phase), int'(PH_1));
    check_val("mid_rst_east_pend", int'(east_pending), 0);
    check_val("mid_rst_west_pend", int'(west_pending), 0);
    exp_nn = PH_1;
    push_normal();
    adv();
    rst = 1'b0;
    trk_restart = 1'b1;
    sb_en = 1'b1;
    smp();
    drain_to(0, "final_drain");
    check_val("sb_left", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
